// File: rtl/program_loader_if.sv
// program_loader_if: byte-receive, start and program-memory write bundle.
// The loader uses the slave modport; a driver or bench uses master.
interface program_loader_if;
  logic        I_START;
  logic [7:0]  I_RX_DATA;
  logic        I_RX_VALID;
  logic        O_MIPS_WrPM;
  logic [31:0] O_MIPS_WrDataPM;
  logic [31:0] O_MIPS_WrDataPMAddr;
  logic        O_LOADING;
  logic        O_LOAD_DONE;
  logic        O_LOAD_ERR;

  modport master (
    output I_START,
    output I_RX_DATA,
    output I_RX_VALID,
    input  O_MIPS_WrPM,
    input  O_MIPS_WrDataPM,
    input  O_MIPS_WrDataPMAddr,
    input  O_LOADING,
    input  O_LOAD_DONE,
    input  O_LOAD_ERR
  );

  modport slave (
    input  I_START,
    input  I_RX_DATA,
    input  I_RX_VALID,
    output O_MIPS_WrPM,
    output O_MIPS_WrDataPM,
    output O_MIPS_WrDataPMAddr,
    output O_LOADING,
    output O_LOAD_DONE,
    output O_LOAD_ERR
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: packs serial bytes big-endian into program-memory words.
// Define LOADER_CHECKSUM_EN to add the trailing XOR checksum byte check.
module program_loader #(
  parameter int          PM_DEPTH  = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic             CLK,
  input  logic             RESET,
  program_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [23:0] r_asm;
  logic [1:0]  r_bcnt;
  logic [31:0] r_idx;
  logic        r_wr;
  logic [31:0] r_wdata;
  logic [31:0] r_waddr;
  logic        r_err;

  logic        w_clear;
  logic        w_accept;
  logic        w_fire;
  logic        w_err_set;
  logic [31:0] w_word;
  logic        w_last_slot;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  assign w_word      = {r_asm, bus.I_RX_DATA};
  assign w_last_slot = (r_idx == 32'(PM_DEPTH - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_accept  = 1'b0;
    w_fire    = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.I_START) begin
          w_next  = S_LOAD;
          w_clear = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.I_RX_VALID) begin
          w_accept = 1'b1;
          if (r_bcnt == 2'd3) begin
            w_fire = 1'b1;
            if (w_word == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
              w_next = S_CHECK;
`else
              w_next = S_DONE;
`endif
            end else if (w_last_slot) begin
              // memory full without a halt word
              w_next    = S_DONE;
              w_err_set = 1'b1;
            end
          end
        end
      end
      S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (bus.I_RX_VALID) begin
          w_next = S_DONE;
          if (bus.I_RX_DATA != r_csum) begin
            w_err_set = 1'b1;
          end
        end
`else
        w_next = S_IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_asm   <= '0;
      r_bcnt  <= '0;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_waddr <= '0;
      r_err   <= 1'b0;
    end else begin
      r_wr <= w_fire;
      if (w_clear) begin
        r_asm  <= '0;
        r_bcnt <= '0;
        r_idx  <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_accept) begin
          r_asm  <= {r_asm[15:0], bus.I_RX_DATA};
          r_bcnt <= r_bcnt + 2'd1;
        end
        if (w_fire) begin
          r_wdata <= w_word;
          r_waddr <= r_idx;
          r_idx   <= r_idx + 32'd1;
        end
        if (w_err_set) begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_csum <= '0;
    end else if (w_clear) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= r_csum ^ bus.I_RX_DATA;
    end
  end
`endif

  assign bus.O_MIPS_WrPM         = r_wr;
  assign bus.O_MIPS_WrDataPM     = r_wdata;
  assign bus.O_MIPS_WrDataPMAddr = r_waddr;
  assign bus.O_LOADING           = (r_state == S_LOAD) ||
                                   (r_state == S_CHECK);
  assign bus.O_LOAD_DONE         = (r_state == S_DONE);
  assign bus.O_LOAD_ERR          = r_err;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed + random bytes vs a word-level model.
// Expected writes are queued; a negedge monitor pops and compares.
module tb_program_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  program_loader_if u_if ();

  program_loader #(
    .PM_DEPTH (DEPTH),
    .HALT_WORD(HALT)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // model: 0 idle, 1 load, 2 check, 3 done
  int           m_mode = 0;
  byte unsigned m_b[$];
  int           m_idx  = 0;
  bit           m_err  = 1'b0;
  byte unsigned m_x    = 8'h00;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic void model(bit r, bit s, bit v, byte unsigned d);
    logic [31:0] w;
    if (r) begin
      m_mode = 0;
      m_err  = 1'b0;
      m_b.delete();
      return;
    end
    case (m_mode)
      0, 3: begin
        if (s) begin
          m_mode = 1;
          m_idx  = 0;
          m_err  = 1'b0;
          m_x    = 8'h00;
          m_b.delete();
        end
      end
      1: begin
        if (v) begin
          m_b.push_back(d);
          m_x = m_x ^ d;
          if (m_b.size() == 4) begin
            w = {m_b[0], m_b[1], m_b[2], m_b[3]};
            exp_q.push_back('{a: 32'(m_idx), d: w});
            m_b.delete();
            if (w == HALT) begin
              m_mode = CS ? 2 : 3;
            end else if (m_idx == DEPTH - 1) begin
              m_mode = 3;
              m_err  = 1'b1;
            end
            m_idx++;
          end
        end
      end
      2: begin
        if (v) begin
          if (d != m_x) m_err = 1'b1;
          m_mode = 3;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic cyc(bit r, bit s, bit v, byte unsigned d);
    rst             = r;
    u_if.I_START    = s;
    u_if.I_RX_VALID = v;
    u_if.I_RX_DATA  = d;
    model(r, s, v, d);
    @(posedge clk);
    #1;
    chk("loading", 32'(u_if.O_LOADING), 32'(m_mode == 1 || m_mode == 2));
    chk("done", 32'(u_if.O_LOAD_DONE), 32'(m_mode == 3));
    chk("err", 32'(u_if.O_LOAD_ERR), 32'(m_err));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00);
  endtask

  task automatic start();
    cyc(0, 1, 0, 8'h00);
  endtask

  task automatic send(byte unsigned d);
    cyc(0, 0, 1, d);
  endtask

  task automatic send_halt();
    for (int i = 0; i < 4; i++) send(8'hFF);
    if (CS) send(8'h00);
  endtask

  // write monitor: pulses pop the scoreboard, otherwise outputs must hold
  logic [31:0] last_a  = '0;
  logic [31:0] last_d  = '0;
  bit          rst_prv = 1'b1;
  wr_t         e;

  always @(negedge clk) begin
    if (rst_prv) begin
      last_a = '0;
      last_d = '0;
      chk("rst_wrpm", 32'(u_if.O_MIPS_WrPM), 32'd0);
    end
    if (u_if.O_MIPS_WrPM === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %h data %h, required none",
                 u_if.O_MIPS_WrDataPMAddr, u_if.O_MIPS_WrDataPM);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", u_if.O_MIPS_WrDataPMAddr, e.a);
        chk("wr_data", u_if.O_MIPS_WrDataPM, e.d);
        last_a = e.a;
        last_d = e.d;
      end
    end else begin
      chk("hold_addr", u_if.O_MIPS_WrDataPMAddr, last_a);
      chk("hold_data", u_if.O_MIPS_WrDataPM, last_d);
    end
    rst_prv = rst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.I_START    = 1'b0;
    u_if.I_RX_VALID = 1'b0;
    u_if.I_RX_DATA  = 8'h00;

    cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'h24);
    chk("rst_data", u_if.O_MIPS_WrDataPM, 32'd0);
    chk("rst_addr", u_if.O_MIPS_WrDataPMAddr, 32'd0);
    idle(2);

    // early bytes ignored; start inside load ignored
    send(8'h11);
    send(8'h22);
    cyc(0, 1, 1, 8'h33);
    send(8'h01);
    send(8'h02);
    cyc(0, 1, 1, 8'h03);
    send(8'h04);
    send_halt();
    idle(2);

    // reference program
    start();
    send(8'h24); send(8'h08); send(8'h00); send(8'h05);
    send_halt();
    idle(2);

    // overflow, then a stray byte
    start();
    for (int i = 0; i < 17; i++) send(8'h11);
    chk("ovf_err", 32'(u_if.O_LOAD_ERR), 32'd1);
    idle(2);

    // reset mid-word discards the partial word
    start();
    send(8'hAA);
    send(8'hBB);
    cyc(1, 0, 0, 8'h00);
    start();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send_halt();

    // back-to-back bytes across the write pulse
    start();
    for (int i = 0; i < 8; i++) send(8'(i));
    send_halt();
    idle(2);

`ifdef LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      start();
      send(8'h12); send(8'h34); send(8'h56); send(8'h78);
      for (int i = 0; i < 4; i++) send(8'hFF);
      send(k == 0 ? 8'h08 : 8'h09);
      chk("csum_err", 32'(u_if.O_LOAD_ERR), 32'(k));
    end
`endif

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(149) == 0,
          $urandom_range(24) == 0,
          $urandom_range(2) != 0,
          ($urandom_range(2) == 0) ? 8'hFF : 8'($urandom));
    end
    idle(4);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter PM_DEPTH, default 32, is the program-memory capacity in 32-bit words.
REQ-002 Parameter HALT_WORD, default 32'hFFFFFFFF, is the word that terminates a program image.
REQ-003 CLK  input  1  is the single clock; all state changes occur on the rising edge.
REQ-004 RESET  input  1  is the reset, synchronous and active-high.
REQ-005 I_START  input  1  is a one-cycle pulse that arms a new load.
REQ-006 I_RX_DATA  input  8  is the incoming program byte from the serial receiver.
REQ-007 I_RX_VALID  input  1  is a one-cycle strobe qualifying I_RX_DATA.
REQ-008 O_MIPS_WrPM  output  1  is the program-memory write strobe to MIPS2.
REQ-009 O_MIPS_WrDataPM  output  32  is the program-memory write data.
REQ-010 O_MIPS_WrDataPMAddr  output  32  is the program-memory word index.
REQ-011 O_LOADING  output  1  is high while the state is LOAD or CHECK.
REQ-012 O_LOAD_DONE  output  1  is high while the state is DONE.
REQ-013 O_LOAD_ERR  output  1  is the sticky load-error flag, cleared by I_START or RESET.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, CHECK and DONE.
REQ-015 In IDLE or DONE, I_START SHALL move the FSM to LOAD; the same cycle clears the word index, byte counter, assembly register, checksum and O_LOAD_ERR.
REQ-016 Bytes arriving in IDLE or DONE SHALL be ignored, including a byte coincident with I_START.
REQ-017 In LOAD, bytes SHALL be assembled big-endian: the first byte maps to [31:24] and the fourth byte to [7:0].
REQ-018 The cycle after the fourth byte is accepted, O_MIPS_WrPM SHALL pulse high for exactly one cycle, with the assembled word on the data output and the current index on the address output.
REQ-019 The word index SHALL increment by 1 after each write, starting at 0.
REQ-020 O_MIPS_WrDataPM and O_MIPS_WrDataPMAddr SHALL hold their last values when O_MIPS_WrPM is low.
REQ-021 A completed word equal to HALT_WORD SHALL still be written, and the FSM SHALL then go to CHECK if the checksum feature is compiled in, otherwise to DONE.
REQ-022 If the write at index PM_DEPTH-1 is not HALT_WORD, the FSM SHALL go to DONE and set O_LOAD_ERR (overflow); no write beyond PM_DEPTH-1 occurs.
REQ-023 Byte valids arriving during the O_MIPS_WrPM pulse cycle SHALL be accepted as the first byte of the next word (no lost bytes).
REQ-024 I_START asserted during LOAD or CHECK SHALL be ignored.

Reset
REQ-025 RESET SHALL force state IDLE, and drive O_MIPS_WrPM, O_MIPS_WrDataPM, O_MIPS_WrDataPMAddr, O_LOADING, O_LOAD_DONE and O_LOAD_ERR to 0.
REQ-026 RESET mid-load SHALL discard the partial word, and no write strobe SHALL follow.
REQ-027 RESET SHALL take priority over I_START and I_RX_VALID in the same cycle.

Configuration
REQ-028 Macro LOADER_CHECKSUM_EN defined: a running XOR of every accepted byte, including the halt word's bytes, is kept. In CHECK, the next accepted byte SHALL be compared with that XOR; a mismatch sets O_LOAD_ERR; the FSM then goes to DONE.
REQ-029 Macro LOADER_CHECKSUM_EN undefined: no checksum logic SHALL exist and CHECK SHALL be unreachable.

Verification
REQ-030 Reset, I_START, then bytes 24 08 00 05 FF FF FF FF -> a write of 32'h24080005 at index 0, then 32'hFFFFFFFF at index 1; O_LOAD_DONE=1; O_LOAD_ERR=0.
REQ-031 PM_DEPTH=4, I_START, then 16 bytes of 0x11 -> four writes at indices 0..3; O_LOAD_DONE=1; O_LOAD_ERR=1; a 17th byte produces no write.
REQ-032 I_START, bytes AA BB, then RESET, then I_START and bytes 01 02 03 04 -> a single write of 32'h01020304 at index 0.
REQ-033 Back-to-back I_RX_VALID every cycle for 8 bytes 00..07 -> writes 32'h00010203 and 32'h04050607 at indices 0 and 1, with no byte dropped.
REQ-034 LOADER_CHECKSUM_EN defined: bytes 12 34 56 78 FF FF FF FF then 0x08 -> O_LOAD_ERR=0; repeating the load with a final byte of 0x09 -> O_LOAD_ERR=1.
REQ-035 Bytes received before any I_START, and I_START pulsed during LOAD -> no writes from the early bytes, and the load in progress continues unaffected.
